// File: rtl/maquina_necesidad_param.sv
// Food-need state machine with an internally owned level: timed decay, timed refill
// while feeding, and held-button lockout. Optional starvation alert: ALERTA_CRITICA_EN.
module maquina_necesidad_param #(
  parameter int LEVEL_W      = 3,
  parameter int HUNGRY_TH    = 5,
  parameter int STARVE_TH    = 2,
  parameter int DECAY_TICKS  = 50000000,
  parameter int FEED_TICKS   = 12500000,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Boton_Comida,
  output logic [LEVEL_W-1:0] Nivel_Comida,
  output logic [1:0]         Visualizacion,
  output logic               Activo_Comida,
  output logic [7:0]         Salida_Codigo,
  output logic               Alerta_Critica
);

  localparam int DW = $clog2(DECAY_TICKS);
  localparam int FW = $clog2(FEED_TICKS);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = {LEVEL_W{1'b1}};
  localparam logic [LEVEL_W-1:0] LEVEL_ZERO = {LEVEL_W{1'b0}};
  localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(32'd1);
  localparam logic [LEVEL_W-1:0] HUNGRY_LV  = LEVEL_W'(HUNGRY_TH);
  localparam logic [LEVEL_W-1:0] STARVE_LV  = LEVEL_W'(STARVE_TH);
  localparam logic [DW-1:0]      DECAY_LAST = DW'(DECAY_TICKS - 1);
  localparam logic [FW-1:0]      FEED_LAST  = FW'(FEED_TICKS - 1);

  if (!(STARVE_TH > 0 && STARVE_TH < HUNGRY_TH && HUNGRY_TH <= (2 ** LEVEL_W) - 1) ||
      LEVEL_W < 1 || LEVEL_W > 4 || DECAY_TICKS < 2 || FEED_TICKS < 2 || STARVE_LIMIT < 1) begin : g_param_check
    $error("maquina_necesidad_param: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_HAMBRE     = 2'b01,
    ST_DESNUTRIDO = 2'b10,
    ST_COMIENDO   = 2'b11
  } estado_t;

  estado_t            estado_r, estado_next_s;
  logic [LEVEL_W-1:0] nivel_r, nivel_next_s;
  logic [DW-1:0]      decay_cnt_r, decay_cnt_next_s;
  logic [FW-1:0]      feed_cnt_r, feed_cnt_next_s;
  logic               lockout_r, lockout_next_s;
  logic               decay_tick_s, feed_tick_s, feed_s, lleno_exit_s;
  logic [1:0]         vis_r;
  logic               activo_r;
  logic [7:0]         codigo_r;

  function automatic estado_t clasificar(input logic [LEVEL_W-1:0] nivel);
    if (nivel < STARVE_LV) begin
      return ST_DESNUTRIDO;
    end else if (nivel < HUNGRY_LV) begin
      return ST_HAMBRE;
    end else begin
      return ST_IDLE;
    end
  endfunction

  // Timers, level arithmetic, next state and lockout.
  always_comb begin
    feed_s           = Boton_Comida & ~lockout_r;
    decay_tick_s     = 1'b0;
    feed_tick_s      = 1'b0;
    lleno_exit_s     = 1'b0;
    decay_cnt_next_s = decay_cnt_r;
    feed_cnt_next_s  = {FW{1'b0}};
    estado_next_s    = estado_r;
    nivel_next_s     = nivel_r;

    // Decay counter is frozen (not cleared) while eating; the feed counter only runs while eating.
    if (estado_r == ST_COMIENDO) begin
      if (feed_cnt_r == FEED_LAST) begin
        feed_tick_s = 1'b1;
      end else begin
        feed_cnt_next_s = feed_cnt_r + FW'(32'd1);
      end
    end else begin
      if (decay_cnt_r == DECAY_LAST) begin
        decay_tick_s     = 1'b1;
        decay_cnt_next_s = {DW{1'b0}};
      end else begin
        decay_cnt_next_s = decay_cnt_r + DW'(32'd1);
      end
    end

    if (decay_tick_s && nivel_r != LEVEL_ZERO) begin
      nivel_next_s = nivel_r - LEVEL_ONE;
    end else if (feed_tick_s && nivel_r != LEVEL_MAX) begin
      nivel_next_s = nivel_r + LEVEL_ONE;
    end else begin
      nivel_next_s = nivel_r;
    end

    case (estado_r)
      ST_IDLE: begin
        estado_next_s = clasificar(nivel_r);
      end
      ST_HAMBRE: begin
        if (feed_s) begin
          estado_next_s = ST_COMIENDO;
        end else begin
          estado_next_s = clasificar(nivel_r);
        end
      end
      ST_DESNUTRIDO: begin
        if (feed_s) begin
          estado_next_s = ST_COMIENDO;
        end else begin
          estado_next_s = ST_DESNUTRIDO;
        end
      end
      ST_COMIENDO: begin
        if (nivel_r == LEVEL_MAX) begin
          estado_next_s = ST_IDLE;
          lleno_exit_s  = 1'b1;
        end else if (!Boton_Comida) begin
          estado_next_s = clasificar(nivel_r);
        end else begin
          estado_next_s = ST_COMIENDO;
        end
      end
      default: begin
        estado_next_s = ST_IDLE;
      end
    endcase

    // A released button always drops the lockout, even on the cycle a full exit happens.
    lockout_next_s = Boton_Comida & (lockout_r | lleno_exit_s);
  end

  // State, level, timers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_r    <= ST_IDLE;
      nivel_r     <= LEVEL_MAX;
      decay_cnt_r <= {DW{1'b0}};
      feed_cnt_r  <= {FW{1'b0}};
      lockout_r   <= 1'b0;
      vis_r       <= 2'b00;
      activo_r    <= 1'b1;
      codigo_r    <= {2'b00, 2'b00, 4'(LEVEL_MAX)};
    end else begin
      estado_r    <= estado_next_s;
      nivel_r     <= nivel_next_s;
      decay_cnt_r <= decay_cnt_next_s;
      feed_cnt_r  <= feed_cnt_next_s;
      lockout_r   <= lockout_next_s;
      vis_r       <= estado_next_s;
      activo_r    <= (estado_next_s != ST_COMIENDO);
      codigo_r    <= {2'b00, estado_next_s, 4'(nivel_next_s)};
    end
  end

  assign Nivel_Comida  = nivel_r;
  assign Visualizacion = vis_r;
  assign Activo_Comida = activo_r;
  assign Salida_Codigo = codigo_r;

`ifdef ALERTA_CRITICA_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt_r, starve_cnt_next_s;
  logic          alerta_r, alerta_next_s;

  // Count decay periods spent starving at zero; the alert holds until feeding starts.
  always_comb begin
    starve_cnt_next_s = {SW{1'b0}};
    alerta_next_s     = alerta_r;
    if (estado_r == ST_DESNUTRIDO && estado_next_s == ST_DESNUTRIDO) begin
      if (decay_tick_s && nivel_r == LEVEL_ZERO && starve_cnt_r != STARVE_LAST) begin
        starve_cnt_next_s = starve_cnt_r + SW'(32'd1);
      end else begin
        starve_cnt_next_s = starve_cnt_r;
      end
    end else begin
      starve_cnt_next_s = {SW{1'b0}};
    end
    if (estado_next_s == ST_COMIENDO) begin
      alerta_next_s = 1'b0;
    end else if (starve_cnt_next_s == STARVE_LAST) begin
      alerta_next_s = 1'b1;
    end else begin
      alerta_next_s = alerta_r;
    end
  end

  // Starvation counter and sticky alert register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_r <= {SW{1'b0}};
      alerta_r     <= 1'b0;
    end else begin
      starve_cnt_r <= starve_cnt_next_s;
      alerta_r     <= alerta_next_s;
    end
  end

  assign Alerta_Critica = alerta_r;
`else
  assign Alerta_Critica = 1'b0;
`endif

endmodule

// File: tb/tb_maquina_necesidad_param.sv
// Self-checking bench for maquina_necesidad_param: directed table, corner sequences
// and randomized button activity against a behavioural model.
module tb_maquina_necesidad_param;

  localparam int LW = 3, HT = 5, ST = 2, DT = 4, FT = 2, SL = 2;
  localparam int LMAX = (1 << LW) - 1;
  localparam int S_IDLE = 0, S_HAM = 1, S_DES = 2, S_COM = 3;
`ifdef ALERTA_CRITICA_EN
  localparam bit ALERT_ON = 1'b1;
`else
  localparam bit ALERT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Boton_Comida = 1'b0;
  logic [LW-1:0] Nivel_Comida;
  logic [1:0]    Visualizacion;
  logic          Activo_Comida;
  logic [7:0]    Salida_Codigo;
  logic          Alerta_Critica;

  maquina_necesidad_param #(
    .LEVEL_W(LW), .HUNGRY_TH(HT), .STARVE_TH(ST),
    .DECAY_TICKS(DT), .FEED_TICKS(FT), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .reset(reset), .Boton_Comida(Boton_Comida),
    .Nivel_Comida(Nivel_Comida), .Visualizacion(Visualizacion),
    .Activo_Comida(Activo_Comida), .Salida_Codigo(Salida_Codigo),
    .Alerta_Critica(Alerta_Critica)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: state by display code, level, timer phases, lockout, starvation.
  int m_state, m_level, m_dph, m_fph, m_starve;
  bit m_lock, m_alert;

  function automatic int classify(input int lvl);
    if (lvl < ST) return S_DES;
    else if (lvl < HT) return S_HAM;
    else return S_IDLE;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_level = LMAX; m_dph = 0; m_fph = 0;
    m_starve = 0; m_lock = 1'b0; m_alert = 1'b0;
  endtask

  task automatic model_step(input bit b);
    bit dtick = 1'b0, ftick = 1'b0, full_exit = 1'b0, feed;
    int ns;
    feed = b && !m_lock;
    if (m_state == S_COM) begin
      if (m_fph == FT - 1) begin ftick = 1'b1; m_fph = 0; end
      else m_fph = m_fph + 1;
    end else begin
      m_fph = 0;
      if (m_dph == DT - 1) begin dtick = 1'b1; m_dph = 0; end
      else m_dph = m_dph + 1;
    end
    case (m_state)
      S_IDLE: ns = classify(m_level);
      S_HAM:  ns = feed ? S_COM : classify(m_level);
      S_DES:  ns = feed ? S_COM : S_DES;
      default: begin
        if (m_level == LMAX) begin ns = S_IDLE; full_exit = 1'b1; end
        else if (!b) ns = classify(m_level);
        else ns = S_COM;
      end
    endcase
    if (m_state == S_DES && ns == S_DES) begin
      if (dtick && m_level == 0 && m_starve < SL) m_starve = m_starve + 1;
    end else begin
      m_starve = 0;
    end
    if (ns == S_COM) m_alert = 1'b0;
    else if (m_starve >= SL) m_alert = 1'b1;
    if (dtick && m_level > 0) m_level = m_level - 1;
    if (ftick && m_level < LMAX) m_level = m_level + 1;
    m_lock = b && (m_lock || full_exit);
    m_state = ns;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model.level", 32'(Nivel_Comida), m_level);
    chk("model.vis", 32'(Visualizacion), m_state);
    chk("model.activo", 32'(Activo_Comida), (m_state == S_COM) ? 0 : 1);
    chk("model.codigo", 32'(Salida_Codigo), m_state * 16 + m_level);
    chk("model.alerta", 32'(Alerta_Critica), (ALERT_ON && m_alert) ? 1 : 0);
  endtask

  task automatic cycle(input bit b);
    Boton_Comida = b;
    @(posedge clk);
    model_step(b);
    #1;
    check_model();
  endtask

  task automatic run(input bit b, input int n);
    for (int i = 0; i < n; i++) cycle(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    Boton_Comida = 1'b0;
    model_reset();
    #1;
    chk("reset.level", 32'(Nivel_Comida), 7);
    chk("reset.vis", 32'(Visualizacion), 0);
    chk("reset.activo", 32'(Activo_Comida), 1);
    chk("reset.codigo", 32'(Salida_Codigo), 8'h07);
    chk("reset.alerta", 32'(Alerta_Critica), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    bit btn;
    int n;
    int lvl;
    int vis;
    int act;
    int code;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Edge counts are relative to the previous row; the run starts at reset release.
    tbl.push_back('{1'b0, 3, 7, 0, 1, 8'h07});
    tbl.push_back('{1'b0, 1, 6, 0, 1, 8'h06});
    tbl.push_back('{1'b0, 8, 4, 0, 1, 8'h04});
    tbl.push_back('{1'b0, 1, 4, 1, 1, 8'h14});
    tbl.push_back('{1'b0, 11, 1, 1, 1, 8'h11});
    tbl.push_back('{1'b0, 1, 1, 2, 1, 8'h21});
    tbl.push_back('{1'b1, 1, 1, 3, 0, 8'h31});
    tbl.push_back('{1'b1, 2, 2, 3, 0, 8'h32});
    tbl.push_back('{1'b1, 10, 7, 3, 0, 8'h37});
    tbl.push_back('{1'b1, 1, 7, 0, 1, 8'h07});
    tbl.push_back('{1'b1, 5, 6, 0, 1, 8'h06});
    tbl.push_back('{1'b0, 1, 5, 0, 1, 8'h05});
    tbl.push_back('{1'b1, 2, 5, 0, 1, 8'h05});

    do_reset();
    foreach (tbl[i]) begin
      run(tbl[i].btn, tbl[i].n);
      chk($sformatf("tbl[%0d].level", i), 32'(Nivel_Comida), tbl[i].lvl);
      chk($sformatf("tbl[%0d].vis", i), 32'(Visualizacion), tbl[i].vis);
      chk($sformatf("tbl[%0d].activo", i), 32'(Activo_Comida), tbl[i].act);
      chk($sformatf("tbl[%0d].codigo", i), 32'(Salida_Codigo), tbl[i].code);
    end

    // Level saturates at zero and stays in DESNUTRIDO.
    do_reset();
    run(1'b0, 40);
    chk("sat.level", 32'(Nivel_Comida), 0);
    chk("sat.vis", 32'(Visualizacion), 2);

    // Feed from HAMBRE at 3, release at 4, decay resumes from the frozen phase.
    do_reset();
    run(1'b0, 16);
    chk("hambre.vis", 32'(Visualizacion), 1);
    run(1'b1, 3);
    chk("eat.level", 32'(Nivel_Comida), 4);
    chk("eat.vis", 32'(Visualizacion), 3);
    run(1'b0, 1);
    chk("release.vis", 32'(Visualizacion), 1);
    chk("release.level", 32'(Nivel_Comida), 4);
    run(1'b0, 2);
    chk("frozen.level_hold", 32'(Nivel_Comida), 4);
    run(1'b0, 1);
    chk("frozen.level_dec", 32'(Nivel_Comida), 3);

    // Asynchronous reset while eating at level 5.
    do_reset();
    run(1'b0, 16);
    run(1'b1, 5);
    chk("pre_rst.level", 32'(Nivel_Comida), 5);
    chk("pre_rst.vis", 32'(Visualizacion), 3);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst.level", 32'(Nivel_Comida), 7);
    chk("async_rst.vis", 32'(Visualizacion), 0);
    chk("async_rst.activo", 32'(Activo_Comida), 1);
    model_reset();
    Boton_Comida = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Starvation alert after two decay periods at level zero.
    do_reset();
    run(1'b0, 35);
    chk("alert.before", 32'(Alerta_Critica), 0);
    run(1'b0, 1);
    chk("alert.set", 32'(Alerta_Critica), ALERT_ON ? 1 : 0);
    run(1'b0, 5);
    chk("alert.sticky", 32'(Alerta_Critica), ALERT_ON ? 1 : 0);
    run(1'b1, 1);
    chk("alert.clear", 32'(Alerta_Critica), 0);
    chk("alert.eating", 32'(Visualizacion), 3);

    // Randomized button runs, with occasional resets.
    do_reset();
    for (int seg = 0; seg < 200; seg++) begin
      if ($urandom_range(0, 24) == 0) do_reset();
      run(1'($urandom_range(0, 1)), int'($urandom_range(1, 24)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
